// File: rtl/meikyuu_pkg.sv
// Shared maze constants, tile codes, direction/FSM enums and the per-tile wall rule
// used by the player-motion stage and the VGA top.
package meikyuu_pkg;

    localparam int P_H_OFFSET = 96;
    localparam int P_V_OFFSET = 2;
    localparam int P_SCR_W    = 640;
    localparam int P_SCR_H    = 480;
    localparam int P_WALL     = 100;
    localparam int P_SPRITE   = 16;
    localparam int P_STEP     = 2;
    localparam int P_TICK_DIV = 416667;
    localparam int P_MAP_W    = 3;
    localparam int P_MAP_H    = 3;

    localparam logic [3:0] TILE_VERTICAL   = 4'd0;
    localparam logic [3:0] TILE_HORIZONTAL = 4'd1;
    localparam logic [3:0] TILE_L1         = 4'd2;
    localparam logic [3:0] TILE_L2         = 4'd3;
    localparam logic [3:0] TILE_L3         = 4'd4;
    localparam logic [3:0] TILE_L4         = 4'd5;
    localparam logic [3:0] TILE_CROSS      = 4'd6;

    typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT} dir_t;

    typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, COMMIT, TRANSIT} state_t;

    // l/r/t/b flag the candidate box overlapping the wall band on that side
    function automatic logic wall_hit(input logic [3:0] tile,
                                      input logic l, input logic r,
                                      input logic t, input logic b);
        case (tile)
            TILE_VERTICAL:   wall_hit = l | r;
            TILE_HORIZONTAL: wall_hit = t | b;
            TILE_L1:         wall_hit = (l & t) | b | r;
            TILE_L2:         wall_hit = (r & t) | b | l;
            TILE_L3:         wall_hit = (r & b) | t | l;
            TILE_L4:         wall_hit = (l & b) | t | r;
            TILE_CROSS:      wall_hit = (l | r) & (t | b);
            default:         wall_hit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/player_motion_if.sv
// Button, tile and position bundle between the stimulus/map side (master) and
// the player-motion stage (slave).
interface player_motion_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [3:0] tile_type;
    logic [9:0] x_pos_out;
    logic [9:0] y_pos_out;
    logic [2:0] mapa_pos_x_out;
    logic [2:0] mapa_pos_y_out;
    logic       blocked;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, tile_type,
        input  x_pos_out, y_pos_out, mapa_pos_x_out, mapa_pos_y_out, blocked
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, tile_type,
        output x_pos_out, y_pos_out, mapa_pos_x_out, mapa_pos_y_out, blocked
    );
endinterface

// File: rtl/player_motion_btn_conditioner.sv
// Two-flop synchroniser for one raw button; with PLAYER_DEBOUNCE_EN defined the
// synchronised level must also hold for 500000 cycles (20 ms) before it is passed on.
module btn_conditioner (
    input  logic CLOCK_25,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_clean
);

    logic [1:0] sync_q;

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], btn_raw};
    end

`ifdef PLAYER_DEBOUNCE_EN
    localparam logic [18:0] DEB_LAST = 19'd499999;

    logic [18:0] stable_cnt;
    logic        filt_q;

    // Any return to the filtered level restarts the stability window
    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            stable_cnt <= '0;
            filt_q     <= 1'b0;
        end else if (sync_q[1] == filt_q) begin
            stable_cnt <= '0;
        end else if (stable_cnt == DEB_LAST) begin
            stable_cnt <= '0;
            filt_q     <= sync_q[1];
        end else begin
            stable_cnt <= stable_cnt + 19'd1;
        end
    end

    assign btn_clean = filt_q;
`else
    assign btn_clean = sync_q[1];
`endif

endmodule

// File: rtl/player_motion.sv
// Player movement: conditioned buttons -> per-tick move request, checked against the
// current tile's walls, committed on screen or carried into the neighbouring map tile.
module player_motion
    import meikyuu_pkg::*;
#(
    parameter int H_OFFSET = P_H_OFFSET,
    parameter int V_OFFSET = P_V_OFFSET,
    parameter int SCR_W    = P_SCR_W,
    parameter int SCR_H    = P_SCR_H,
    parameter int WALL     = P_WALL,
    parameter int SPRITE   = P_SPRITE,
    parameter int STEP     = P_STEP,
    parameter int TICK_DIV = P_TICK_DIV,
    parameter int MAP_W    = P_MAP_W,
    parameter int MAP_H    = P_MAP_H
) (
    input  logic            CLOCK_25,
    input  logic            reset,
    player_motion_if.slave  bus
);

    localparam int         CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [9:0] START_X = 10'(H_OFFSET + (SCR_W - SPRITE) / 2);
    localparam logic [9:0] START_Y = 10'(V_OFFSET + (SCR_H - SPRITE) / 2);
    localparam logic [9:0] STEP_V  = 10'(STEP);
    localparam logic [9:0] X_MIN   = 10'(H_OFFSET + 1);
    localparam logic [9:0] X_MAX   = 10'(H_OFFSET + SCR_W - SPRITE);
    localparam logic [9:0] Y_MIN   = 10'(V_OFFSET + 1);
    localparam logic [9:0] Y_MAX   = 10'(V_OFFSET + SCR_H - SPRITE);
    localparam logic [2:0] MAP_X0  = 3'(MAP_W / 2);
    localparam logic [2:0] MAP_Y0  = 3'(MAP_H / 2);
    localparam logic [2:0] MAP_XL  = 3'(MAP_W - 1);
    localparam logic [2:0] MAP_YL  = 3'(MAP_H - 1);

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    logic up_s, down_s, left_s, right_s;

    btn_conditioner u_up    (.CLOCK_25(CLOCK_25), .reset(reset), .btn_raw(bus.btn_up),    .btn_clean(up_s));
    btn_conditioner u_down  (.CLOCK_25(CLOCK_25), .reset(reset), .btn_raw(bus.btn_down),  .btn_clean(down_s));
    btn_conditioner u_left  (.CLOCK_25(CLOCK_25), .reset(reset), .btn_raw(bus.btn_left),  .btn_clean(left_s));
    btn_conditioner u_right (.CLOCK_25(CLOCK_25), .reset(reset), .btn_raw(bus.btn_right), .btn_clean(right_s));

    dir_t dir_req;

    always_comb begin
        dir_req = NONE;
        if (up_s)         dir_req = UP;
        else if (down_s)  dir_req = DOWN;
        else if (left_s)  dir_req = LEFT;
        else if (right_s) dir_req = RIGHT;
    end

    state_t     state;
    dir_t       dir_q;
    logic [9:0] cx, cy, x_pos, y_pos;
    logic [2:0] map_x, map_y;
    logic       blocked_q;

    // Candidate box tests in 11 bits so cx+SPRITE near the right edge cannot wrap
    logic [10:0] cx_e, cy_e;
    logic        wall_l, wall_r, wall_t, wall_b;
    logic        edge_cross;

    assign cx_e   = {1'b0, cx};
    assign cy_e   = {1'b0, cy};
    assign wall_l = cx_e < 11'(H_OFFSET + WALL);
    assign wall_r = (cx_e + 11'(SPRITE)) > 11'(H_OFFSET + SCR_W - WALL);
    assign wall_t = cy_e < 11'(V_OFFSET + WALL);
    assign wall_b = (cy_e + 11'(SPRITE)) > 11'(V_OFFSET + SCR_H - WALL);

    assign edge_cross = (cx_e < 11'(H_OFFSET + 1))
                      | ((cx_e + 11'(SPRITE)) > 11'(H_OFFSET + SCR_W))
                      | (cy_e < 11'(V_OFFSET + 1))
                      | ((cy_e + 11'(SPRITE)) > 11'(V_OFFSET + SCR_H));

    always_ff @(posedge CLOCK_25 or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dir_q     <= NONE;
            cx        <= START_X;
            cy        <= START_Y;
            x_pos     <= START_X;
            y_pos     <= START_Y;
            map_x     <= MAP_X0;
            map_y     <= MAP_Y0;
            blocked_q <= 1'b0;
        end else begin
            blocked_q <= 1'b0;
            case (state)
                IDLE: if (tick) state <= SAMPLE;

                SAMPLE: begin
                    dir_q <= dir_req;
                    cx    <= x_pos;
                    cy    <= y_pos;
                    case (dir_req)
                        UP:      cy <= y_pos - STEP_V;
                        DOWN:    cy <= y_pos + STEP_V;
                        LEFT:    cx <= x_pos - STEP_V;
                        RIGHT:   cx <= x_pos + STEP_V;
                        default: ;
                    endcase
                    state <= (dir_req == NONE) ? IDLE : CHECK;
                end

                CHECK: begin
                    if (wall_hit(bus.tile_type, wall_l, wall_r, wall_t, wall_b)) begin
                        blocked_q <= 1'b1;
                        state     <= IDLE;
                    end else if (edge_cross) begin
                        state <= TRANSIT;
                    end else begin
                        state <= COMMIT;
                    end
                end

                COMMIT: begin
                    x_pos <= cx;
                    y_pos <= cy;
                    state <= IDLE;
                end

                // Only the moving axis can have crossed, so dir_q names the exit edge
                TRANSIT: begin
                    case (dir_q)
                        LEFT:
                            if (map_x != 3'd0) begin map_x <= map_x - 3'd1; x_pos <= X_MAX; end
                            else blocked_q <= 1'b1;
                        RIGHT:
                            if (map_x != MAP_XL) begin map_x <= map_x + 3'd1; x_pos <= X_MIN; end
                            else blocked_q <= 1'b1;
                        UP:
                            if (map_y != 3'd0) begin map_y <= map_y - 3'd1; y_pos <= Y_MAX; end
                            else blocked_q <= 1'b1;
                        DOWN:
                            if (map_y != MAP_YL) begin map_y <= map_y + 3'd1; y_pos <= Y_MIN; end
                            else blocked_q <= 1'b1;
                        default: ;
                    endcase
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.x_pos_out      = x_pos;
    assign bus.y_pos_out      = y_pos;
    assign bus.mapa_pos_x_out = map_x;
    assign bus.mapa_pos_y_out = map_y;
    assign bus.blocked        = blocked_q;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: every visible move or blocked pulse is
// compared against a plain-arithmetic model of one player step.
module tb_player_motion;
    import meikyuu_pkg::*;

    localparam int TDIV = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    player_motion_if bus();

    player_motion #(.TICK_DIV(TDIV)) dut (
        .CLOCK_25(clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state and observation bookkeeping
    int m_x, m_y, m_mx, m_my;
    int px, py, pmx, pmy;
    int ev_cnt, blk_cnt;
    logic [3:0] cur_btn;   // {right,left,down,up}
    int cur_tile;

    task automatic model_reset();
        m_x = 408; m_y = 234; m_mx = 1; m_my = 1;
        px = 408; py = 234; pmx = 1; pmy = 1;
    endtask

    // One movement tick with buttons b held, following the documented rules
    task automatic model_move(input logic [3:0] b, input int tile, output bit blk);
        int dx, dy, cx, cy;
        bit l, r, t, bo, hit;
        dx = 0; dy = 0;
        if (b[0])      dy = -2;
        else if (b[1]) dy = 2;
        else if (b[2]) dx = -2;
        else if (b[3]) dx = 2;
        cx = m_x + dx; cy = m_y + dy;
        l  = cx < 196;  r  = cx + 16 > 636;
        t  = cy < 102;  bo = cy + 16 > 382;
        case (tile)
            0: hit = l || r;
            1: hit = t || bo;
            2: hit = (l && t) || bo || r;
            3: hit = (r && t) || bo || l;
            4: hit = (r && bo) || t || l;
            5: hit = (l && bo) || t || r;
            6: hit = (l || r) && (t || bo);
            default: hit = 0;
        endcase
        blk = 0;
        if (hit) blk = 1;
        else if (cx < 97)        begin if (m_mx > 0) begin m_mx--; m_x = 720; end else blk = 1; end
        else if (cx + 16 > 736)  begin if (m_mx < 2) begin m_mx++; m_x = 97;  end else blk = 1; end
        else if (cy < 3)         begin if (m_my > 0) begin m_my--; m_y = 466; end else blk = 1; end
        else if (cy + 16 > 482)  begin if (m_my < 2) begin m_my++; m_y = 3;   end else blk = 1; end
        else begin m_x = cx; m_y = cy; end
    endtask

    // Any output change or blocked pulse is one player step; score it against the model
    task automatic track_cycle();
        bit eb, ev;
        ev = (bus.blocked !== 1'b0) || (bus.x_pos_out !== 10'(px)) || (bus.y_pos_out !== 10'(py))
          || (bus.mapa_pos_x_out !== 3'(pmx)) || (bus.mapa_pos_y_out !== 3'(pmy));
        if (bus.blocked === 1'b1) blk_cnt++;
        if (ev) begin
            ev_cnt++;
            model_move(cur_btn, cur_tile, eb);
            n_tests++;
            if (bus.x_pos_out !== 10'(m_x)) begin n_fail++;
                $display("FAIL step_x: got %0d expected %0d", bus.x_pos_out, m_x); end
            n_tests++;
            if (bus.y_pos_out !== 10'(m_y)) begin n_fail++;
                $display("FAIL step_y: got %0d expected %0d", bus.y_pos_out, m_y); end
            n_tests++;
            if (bus.mapa_pos_x_out !== 3'(m_mx)) begin n_fail++;
                $display("FAIL step_map_x: got %0d expected %0d", bus.mapa_pos_x_out, m_mx); end
            n_tests++;
            if (bus.mapa_pos_y_out !== 3'(m_my)) begin n_fail++;
                $display("FAIL step_map_y: got %0d expected %0d", bus.mapa_pos_y_out, m_my); end
            n_tests++;
            if (bus.blocked !== eb) begin n_fail++;
                $display("FAIL step_blocked: got %0b expected %0b", bus.blocked, eb); end
        end
        px = int'(bus.x_pos_out); py = int'(bus.y_pos_out);
        pmx = int'(bus.mapa_pos_x_out); pmy = int'(bus.mapa_pos_y_out);
    endtask

    // Hold buttons b until n steps are seen (bounded), release, then confirm no extra steps
    task automatic move_n(input logic [3:0] b, input int tile, input int n);
        cur_btn = b; cur_tile = tile; ev_cnt = 0; blk_cnt = 0;
        bus.tile_type = 4'(tile);
        {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = b;
        for (int c = 0; c < n * TDIV + 40 && ev_cnt < n; c++) begin
            @(negedge clk); track_cycle();
        end
        {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up} = 4'b0000;
        repeat (24) begin @(negedge clk); track_cycle(); end
        n_tests++;
        if (ev_cnt !== n) begin n_fail++;
            $display("FAIL step_count: got %0d expected %0d (buttons %b tile %0d)", ev_cnt, n, b, tile); end
    endtask

    task automatic test_reset();
        bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.tile_type = 4'd7;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (bus.x_pos_out !== 10'd408) begin n_fail++; $display("FAIL reset_x: got %0d expected 408", bus.x_pos_out); end
        n_tests++; if (bus.y_pos_out !== 10'd234) begin n_fail++; $display("FAIL reset_y: got %0d expected 234", bus.y_pos_out); end
        n_tests++; if (bus.mapa_pos_x_out !== 3'd1) begin n_fail++; $display("FAIL reset_map_x: got %0d expected 1", bus.mapa_pos_x_out); end
        n_tests++; if (bus.mapa_pos_y_out !== 3'd1) begin n_fail++; $display("FAIL reset_map_y: got %0d expected 1", bus.mapa_pos_y_out); end
        n_tests++; if (bus.blocked !== 1'b0) begin n_fail++; $display("FAIL reset_blocked: got %0b expected 0", bus.blocked); end
        rst_n = 1'b1;
        model_reset();
        move_n(4'b0000, 7, 0);
        repeat (100) begin @(negedge clk); track_cycle(); end
        n_tests++; if (ev_cnt !== 0) begin n_fail++; $display("FAIL idle_quiet: got %0d steps expected 0", ev_cnt); end
    endtask

    task automatic test_move_right();
        move_n(4'b1000, 6, 10);
        n_tests++; if (bus.x_pos_out !== 10'd428) begin n_fail++; $display("FAIL right_x: got %0d expected 428", bus.x_pos_out); end
        n_tests++; if (bus.y_pos_out !== 10'd234) begin n_fail++; $display("FAIL right_y: got %0d expected 234", bus.y_pos_out); end
    endtask

    task automatic test_wall_left();
        move_n(4'b0100, 7, 115);
        n_tests++; if (bus.x_pos_out !== 10'd198) begin n_fail++; $display("FAIL left_to_198: got %0d expected 198", bus.x_pos_out); end
        move_n(4'b0100, 0, 2);
        n_tests++; if (bus.x_pos_out !== 10'd196) begin n_fail++; $display("FAIL wall_x: got %0d expected 196", bus.x_pos_out); end
        n_tests++; if (blk_cnt !== 1) begin n_fail++; $display("FAIL wall_pulses: got %0d expected 1", blk_cnt); end
    endtask

    task automatic test_edge_transit();
        move_n(4'b1000, 6, 261);
        n_tests++; if (bus.x_pos_out !== 10'd718) begin n_fail++; $display("FAIL edge_x718: got %0d expected 718", bus.x_pos_out); end
        move_n(4'b1000, 6, 1);
        n_tests++; if (bus.x_pos_out !== 10'd720) begin n_fail++; $display("FAIL edge_x720: got %0d expected 720", bus.x_pos_out); end
        n_tests++; if (bus.mapa_pos_x_out !== 3'd1) begin n_fail++; $display("FAIL edge_map_before: got %0d expected 1", bus.mapa_pos_x_out); end
        move_n(4'b1000, 6, 1);
        n_tests++; if (bus.x_pos_out !== 10'd97) begin n_fail++; $display("FAIL transit_x: got %0d expected 97", bus.x_pos_out); end
        n_tests++; if (bus.mapa_pos_x_out !== 3'd2) begin n_fail++; $display("FAIL transit_map_x: got %0d expected 2", bus.mapa_pos_x_out); end
    endtask

    task automatic test_map_border();
        move_n(4'b1000, 7, 311);
        move_n(4'b1000, 7, 1);
        n_tests++; if (bus.x_pos_out !== 10'd719) begin n_fail++; $display("FAIL border_x: got %0d expected 719", bus.x_pos_out); end
        n_tests++; if (bus.mapa_pos_x_out !== 3'd2) begin n_fail++; $display("FAIL border_map_x: got %0d expected 2", bus.mapa_pos_x_out); end
        n_tests++; if (blk_cnt !== 1) begin n_fail++; $display("FAIL border_pulses: got %0d expected 1", blk_cnt); end
    endtask

    task automatic test_priority();
        move_n(4'b1001, 6, 5);
        n_tests++; if (bus.y_pos_out !== 10'd224) begin n_fail++; $display("FAIL prio_y: got %0d expected 224", bus.y_pos_out); end
        n_tests++; if (bus.x_pos_out !== 10'd719) begin n_fail++; $display("FAIL prio_x: got %0d expected 719", bus.x_pos_out); end
        move_n(4'b1111, 6, 3);
        n_tests++; if (bus.y_pos_out !== 10'd218) begin n_fail++; $display("FAIL prio_all_y: got %0d expected 218", bus.y_pos_out); end
    endtask

    task automatic test_random();
        logic [3:0] b;
        int tile, n;
        for (int i = 0; i < 25; i++) begin
            b    = 4'($urandom_range(0, 15));
            tile = $urandom_range(0, 15);
            n    = (b != 4'b0000) ? $urandom_range(1, 4) : 0;
            move_n(b, tile, n);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        bus.tile_type = 4'd7;
        bus.btn_right = 1'b1;
        for (int c = 0; c < 4 * TDIV && !seen; c++) begin
            @(negedge clk);
            if (dut.state == CHECK) seen = 1;
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL mid_reach_check: got no CHECK within %0d cycles expected one", 4 * TDIV); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.x_pos_out !== 10'd408) begin n_fail++; $display("FAIL mid_reset_x: got %0d expected 408", bus.x_pos_out); end
        n_tests++; if (bus.y_pos_out !== 10'd234) begin n_fail++; $display("FAIL mid_reset_y: got %0d expected 234", bus.y_pos_out); end
        n_tests++; if (bus.mapa_pos_x_out !== 3'd1) begin n_fail++; $display("FAIL mid_reset_map_x: got %0d expected 1", bus.mapa_pos_x_out); end
        n_tests++; if (bus.mapa_pos_y_out !== 3'd1) begin n_fail++; $display("FAIL mid_reset_map_y: got %0d expected 1", bus.mapa_pos_y_out); end
        n_tests++; if (bus.blocked !== 1'b0) begin n_fail++; $display("FAIL mid_reset_blocked: got %0b expected 0", bus.blocked); end
        bus.btn_right = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        move_n(4'b0000, 7, 0);
        move_n(4'b0010, 7, 2);
        n_tests++; if (bus.y_pos_out !== 10'd238) begin n_fail++; $display("FAIL after_reset_y: got %0d expected 238", bus.y_pos_out); end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_move_right();
        test_wall_left();
        test_edge_transit();
        test_map_border();
        test_priority();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
- Player-movement stage directly upstream of the maze VGA top.
- Converts raw direction buttons into a sprite position in VGA counter space (x_pos_out, y_pos_out) and a tile coordinate in the 3x3 world map (mapa_pos_x_out, mapa_pos_y_out).
- Checks every candidate move against the wall geometry of the current tile. Moves the player to the adjacent tile when the sprite leaves the screen through an open edge.

Parameters:
- H_OFFSET, 96, first active h_counter value minus zero offset (horizontal sync width)
- V_OFFSET, 2, vertical active offset
- SCR_W, 640, active width in pixels
- SCR_H, 480, active height in pixels
- WALL, 100, wall thickness in pixels
- SPRITE, 16, sprite edge length
- STEP, 2, pixels moved per movement tick
- TICK_DIV, 416667, CLOCK_25 cycles per movement tick (60 Hz)
- MAP_W, 3, map columns
- MAP_H, 3, map rows

Ports:
- CLOCK_25  in  1  pixel clock, 25 MHz
- reset  in  1  asynchronous, active-low reset
- btn_up  in  1  raw button, active-high, asynchronous to clock
- btn_down  in  1  raw button, active-high, asynchronous to clock
- btn_left  in  1  raw button, active-high, asynchronous to clock
- btn_right  in  1  raw button, active-high, asynchronous to clock
- tile_type  in  4  tile code at the current (mapa_pos_y_out, mapa_pos_x_out), from the top's map lookup
- x_pos_out  out  10  sprite left edge in h_counter space
- y_pos_out  out  10  sprite top edge in v_counter space
- mapa_pos_x_out  out  3  current map column
- mapa_pos_y_out  out  3  current map row
- blocked  out  1  one-cycle pulse: last requested move was rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - x_pos_out=408, y_pos_out=234 (screen centre minus SPRITE/2)
  - mapa_pos_x_out=1, mapa_pos_y_out=1
  - blocked=0, tick counter=0, FSM=IDLE, synchronisers cleared
- Buttons: 2-FF synchroniser each. Priority when several are held: up > down > left > right. One direction is applied per tick.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick=1 for one cycle at wrap.
- FSM states: IDLE, SAMPLE, CHECK, COMMIT, TRANSIT.
  - IDLE -> SAMPLE on tick.
  - SAMPLE: latch direction. No button held -> IDLE. Otherwise compute candidate cx/cy = position ± STEP (10-bit unsigned) -> CHECK.
  - CHECK: evaluate wall predicates on the candidate box using tile_type.
    - Wall hit -> blocked=1 for one cycle, -> IDLE.
    - Candidate crosses a screen edge (cx < H_OFFSET+1, cx+SPRITE > H_OFFSET+SCR_W, cy < V_OFFSET+1, cy+SPRITE > V_OFFSET+SCR_H) -> TRANSIT.
    - Otherwise -> COMMIT.
  - COMMIT: position <= candidate -> IDLE.
  - TRANSIT:
    - Neighbour tile exists (mapa_pos_x_out not 0 when exiting left, not MAP_W-1 when exiting right, and likewise for rows) -> step map coordinate; place sprite on the opposite edge (left exit -> x=H_OFFSET+SCR_W-SPRITE; right exit -> x=H_OFFSET+1; up exit -> y=V_OFFSET+SCR_H-SPRITE; down exit -> y=V_OFFSET+1). Other axis unchanged.
    - Map border -> blocked=1, position unchanged.
    - Either way -> IDLE.
- Wall predicates on the candidate box:
  - L = cx < H_OFFSET+WALL
  - R = cx+SPRITE > H_OFFSET+SCR_W-WALL
  - T = cy < V_OFFSET+WALL
  - B = cy+SPRITE > V_OFFSET+SCR_H-WALL
- Hit function by tile_type:
  - 0: L|R
  - 1: T|B
  - 2: (L&T)|B|R
  - 3: (R&T)|B|L
  - 4: (R&B)|T|L
  - 5: (L&B)|T|R
  - 6: (L|R)&(T|B)
  - 7..15: no walls
- tile_type is sampled only in CHECK. It is at least 2 cycles after any map change, so the top's registered lookup has settled.
- Ticks arriving outside IDLE are dropped. No queueing.
- Outputs are registered. A position or map change is visible the cycle after COMMIT/TRANSIT.
- Reset mid-move aborts immediately. No partial update survives.

Optional Feature:
- PLAYER_DEBOUNCE_EN defined: each synchronised button passes through a debouncer. A 19-bit counter requires a stable level for 500000 cycles (20 ms) before the filtered value changes.
- Undefined: the synchronised value is used directly.

Decomposition:
- Package meikyuu_pkg holds:
  - tile code constants TILE_VERTICAL=0, TILE_HORIZONTAL=1, TILE_L1..TILE_L4=2..5, TILE_CROSS=6
  - dir enum: NONE, UP, DOWN, LEFT, RIGHT
  - fsm state enum
  - screen/wall constants shared with the VGA top
- One sub-module, btn_conditioner: synchroniser plus optional debouncer, instantiated 4x.

Test Plan:
- Reset release, no buttons, TICK_DIV=4 -> outputs stay 408/234/1/1, blocked=0 forever.
- tile_type=6, hold btn_right 10 ticks -> x_pos_out 408->428 in steps of 2, y unchanged.
- tile_type=0, start x=198, hold btn_left -> x 198->196, next tick hits L (196-2=194<196) -> blocked pulse, x stays 196.
- Position x=718, map (1,1), tile_type=6, y=234 is inside the open horizontal band; btn_right -> cx+16=736, no crossing, commit. Press right from x=720 -> edge crossing: map_x=2, x=97.
- Map (2,1), x=720, tile_type=7, btn_right -> blocked=1, map and x unchanged.
- Hold btn_up and btn_right together, tile_type=6 -> only y decrements by 2 per tick.
- Assert reset low mid-CHECK -> all outputs return to reset values in the same cycle.
